// File: rtl/data_ram_pipe_pkg.sv
// data_ram_pipe_pkg
//   Shared bus-width defines, default parameter values, access-size
//   encodings, fault-condition constants and the load/fault helpers used by
//   data_ram_pipe.
package data_ram_pipe_pkg;

   // Bus-width defines
   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   // Default parameter values
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_DEPTH     = 131072;
   localparam int DEF_READ_LAT  = 1;
   localparam int DEF_RSP_DEPTH = 2;

   // req_size encodings
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   // Fault-condition constants: address bits that must be zero per size,
   // and the shift from byte address to word index.
   localparam logic [1:0] HALF_MISALIGN_MASK = 2'b01;
   localparam logic [1:0] WORD_MISALIGN_MASK = 2'b11;
   localparam int         WORD_IDX_SHIFT     = 2;

   function automatic logic is_fault(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input int unsigned depth);
      logic f;
      f = ((addr >> WORD_IDX_SHIFT) >= depth);
      case (size)
         SZ_HALF: f = f | ((addr[1:0] & HALF_MISALIGN_MASK) != 2'b00);
         SZ_WORD: f = f | ((addr[1:0] & WORD_MISALIGN_MASK) != 2'b00);
         SZ_ILL:  f = 1'b1;
         default: ;
      endcase
      return f;
   endfunction

   // Select the addressed byte/half out of a full word and extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*off +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_ram_pipe_rsp_fifo.sv
// rsp_fifo
//   Response buffer with fall-through: when empty, an incoming entry is
//   presented on out_* in the same cycle and is only written to storage if
//   the consumer does not take it. Pointers wrap modulo DEPTH (any DEPTH>=2).
// Ports
//   clk, rst        clock, synchronous active-low reset
//   in_valid/data   entry from the read pipeline (no back-pressure; the
//                   caller guarantees free space)
//   out_valid/data  head of buffer
//   out_ready       head consumed when high with out_valid
module rsp_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             empty, push, pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (count == '0);
   assign out_valid = in_valid || !empty;
   assign out_data  = empty ? in_data : mem[rd_ptr];
   // Bypassed entries never touch storage.
   assign push      = in_valid && !(empty && out_ready);
   assign pop       = out_ready && !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/data_ram_pipe.sv
// data_ram_pipe
//   Byte-addressable data RAM with a fixed-latency read pipeline and a
//   credit-protected response buffer. Stores commit at their acceptance
//   edge; every request (load or store, faulting or not) yields one
//   in-order response READ_LAT cycles after acceptance.
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_we                   1 store, 0 load
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned             load zero-extend (1) / sign-extend (0)
//   req_addr, req_wdata      byte address, right-aligned store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       extended load data (0 for stores/faults), fault
module data_ram_pipe
   import data_ram_pipe_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int READ_LAT  = DEF_READ_LAT,
   parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int FW    = DATA_W + 1;

   logic                        accept, fault, rsp_hs;
   logic [IDX_W-1:0]            idx;
   logic [1:0]                  off;
   logic [LANES-1:0]            be;
   logic [LANES-1:0][7:0]       wlane, rd_word;
   logic [CNT_W-1:0]            out_cnt;
   logic [READ_LAT-1:0]         vld_pipe;

   assign accept = req_valid && req_ready;
   assign fault  = is_fault(req_size, req_addr, DEPTH);
   assign idx    = req_addr[IDX_W+1:2];
   assign off    = req_addr[1:0];

   // Lane enables and lane-positioned store data. Replicating the data
   // across lanes puts it in position for whichever lanes are enabled.
   always_comb begin
      be    = '0;
      wlane = req_wdata;
      case (req_size)
         SZ_BYTE: begin
            be[off] = 1'b1;
            wlane   = {LANES{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wlane = {(LANES/2){req_wdata[15:0]}};
         end
         SZ_WORD: be = '1;
         default: ;
      endcase
      if (!(accept && req_we && !fault)) be = '0;
   end

   // One array per byte lane: partial stores write only their lanes.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
         if (be[l])  mem[idx] <= wlane[l];
         if (accept) rd_q     <= mem[idx];
      end
      assign rd_word[l] = rd_q;
   end

   // Stage 1: request attributes captured alongside the RAM read.
   logic              s1_we, s1_err, s1_uns;
   logic [1:0]        s1_size, s1_off;
   logic [DATA_W-1:0] s1_rdata;
   logic [FW-1:0]     resp1, pipe_data;

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_we   <= req_we;
         s1_err  <= fault;
         s1_uns  <= req_unsigned;
         s1_size <= req_size;
         s1_off  <= off;
      end
   end

   assign s1_rdata = (s1_we || s1_err) ? '0
                   : load_extract(rd_word, s1_size, s1_off, s1_uns);
   assign resp1    = {s1_err, s1_rdata};

   if (READ_LAT == 2) begin : g_lat2
      logic [FW-1:0] resp2;
      always_ff @(posedge clk) resp2 <= resp1;
      assign pipe_data = resp2;
   end else begin : g_lat1
      assign pipe_data = resp1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_pipe <= '0;
         out_cnt  <= '0;
      end else begin
         vld_pipe[0] <= accept;
         for (int i = READ_LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
         case ({accept, rsp_hs})
            2'b10:   out_cnt <= out_cnt + 1'b1;
            2'b01:   out_cnt <= out_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   logic          fifo_valid;
   logic [FW-1:0] fifo_data;

   rsp_fifo #(.WIDTH(FW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld_pipe[READ_LAT-1]),
      .in_data   (pipe_data),
      .out_valid (fifo_valid),
      .out_data  (fifo_data),
      .out_ready (rsp_ready)
   );

   // Counting buffered and in-flight responses means a new request is only
   // taken when its response is guaranteed a slot.
   assign req_ready = rst && (out_cnt < CNT_W'(RSP_DEPTH));
   assign rsp_valid = rst && fifo_valid;
   assign rsp_rdata = rsp_valid ? fifo_data[DATA_W-1:0] : '0;
   assign rsp_err   = rsp_valid && fifo_data[DATA_W];
   assign rsp_hs    = rsp_valid && rsp_ready;

endmodule

// File: tb/tb_data_ram_pipe.sv
module tb_data_ram_pipe;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0, rst = 1'b0, sel = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;

   logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err;
   logic [31:0] a_rsp_rdata, b_rsp_rdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   // sel routes requests to one DUT; outputs seen through the same mux.
   assign req_ready = sel ? b_req_ready : a_req_ready;
   assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
   assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;

   data_ram_pipe #(.DATA_W(32), .DEPTH(DEPTH), .READ_LAT(1), .RSP_DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(a_req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

   data_ram_pipe #(.DATA_W(32), .DEPTH(DEPTH), .READ_LAT(2), .RSP_DEPTH(3)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(b_req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rd, input logic exp_err);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rd = exp_rd; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_sel(input logic s);
      @(negedge clk);
      sel = s;
   endtask

   // One request, waits for its response; lat counts cycles accept->rsp.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      chk("req_accept", 32'(req_ready), 32'd1);
      if (!req_ready) begin
         req_valid = 1'b0; rd = '0; er = 1'b0; lat = -1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      lat = rsp_valid ? n + 1 : -1;
      rd  = rsp_rdata;
      er  = rsp_err;
   endtask

   // Back-to-back word loads from three known words.
   task automatic stream(input int n, input int lat);
      int sent = 0, got = 0, fa = -1, la = -1, fr = -1, lr = -1;
      logic [31:0] sa [3];
      logic [31:0] sd [3];
      sa = '{32'h0, 32'h10, 32'h20};
      sd = '{32'h11223344, 32'h88995ABB, 32'h1234BABE};
      rsp_ready = 1'b1;
      for (int c = 0; c < n + 20 && got < n; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            chk("stream_data", rsp_rdata, sd[got % 3]);
            if (fr < 0) fr = c;
            lr = c;
            got++;
         end
         req_valid = (sent < n); req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
         req_addr = sa[sent % 3];
         if (req_valid && req_ready) begin
            if (fa < 0) fa = c;
            la = c;
            sent++;
         end
      end
      req_valid = 1'b0;
      chk("stream_count", 32'(got), 32'(n));
      chk("stream_accept_span", 32'(la - fa), 32'(n - 1));
      chk("stream_rsp_span", 32'(lr - fr), 32'(n - 1));
      chk("stream_first_latency", 32'(fr - fa), 32'(lat));
   endtask

   task automatic backpressure();
      int sent = 0, got = 0;
      logic [31:0] pa [3];
      logic [31:0] pe [3];
      pa = '{32'h10, 32'h20, 32'h0};
      pe = '{32'h88995ABB, 32'h1234BABE, 32'h11223344};
      rsp_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 5) begin
            chk("bp_accepted", 32'(sent), 32'd2);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
         end
         if (c >= 5) begin
            chk("bp_hold_rdata", rsp_rdata, pe[0]);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
         end
         req_valid = (sent < 3); req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
         if (sent < 3) req_addr = pa[sent];
         if (req_valid && req_ready) sent++;
      end
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         rsp_ready = 1'b1;
         if (rsp_valid) begin
            chk("bp_drain_order", rsp_rdata, pe[got]);
            got++;
         end
         req_valid = (sent < 3);
         if (sent < 3) req_addr = pa[sent];
         if (req_valid && req_ready) sent++;
      end
      req_valid = 1'b0;
      chk("bp_drain_count", 32'(got), 32'd3);
   endtask

   task automatic reset_seq();
      int sent = 0, stale = 0, lat;
      logic [31:0] rd;
      logic        er;
      rsp_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_valid = (sent < 2); req_size = 2'b10; req_unsigned = 1'b0;
         req_we    = (sent == 0);
         req_addr  = (sent == 0) ? 32'h30 : 32'h10;
         req_wdata = 32'h0BADF00D;
         if (req_valid && req_ready) sent++;
      end
      req_valid = 1'b0;
      chk("rst_pending_accepted", 32'(sent), 32'd2);
      chk("rst_pending_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mid_rdata", rsp_rdata, 32'h0);
      chk("rst_mid_err", 32'(rsp_err), 32'd0);
      rst = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("rst_release_req_ready", 32'(req_ready), 32'd1);
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) stale++;
      end
      chk("rst_no_stale", 32'(stale), 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
      chk("rst_store_kept", rd, 32'h0BADF00D);
      chk("rst_store_kept_err", 32'(er), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      //             we    size   uns   addr         wdata          exp_rd         err
      tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10,  32'h8899AABB, 32'h0,        1'b0));
      tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFF88, 1'b0));
      tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'h00000088, 1'b0));
      tbl.push_back(mk(1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        32'hFFFFAABB, 1'b0));
      tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h00008899, 1'b0));
      tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        32'hFFFFFFBB, 1'b0));
      tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'h000000AA, 1'b0));
      tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h20,  32'hCAFEBABE, 32'h0,        1'b0));
      tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h22,  32'hFFFF1234, 32'h0,        1'b0));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h1234BABE, 1'b0));
      tbl.push_back(mk(1'b1, 2'b00, 1'b0, 32'h11,  32'hA5A5A55A, 32'h0,        1'b0));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h88995ABB, 1'b0));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1));
      tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h21,  32'hDEADBEEF, 32'h0,        1'b1));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h1234BABE, 1'b0));
      tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h23,  32'h00007777, 32'h0,        1'b1));
      tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h21,  32'h0,        32'h0,        1'b1));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h1234BABE, 1'b0));
      tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0,   32'h11223344, 32'h0,        1'b0));
      tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF, 32'h0,       1'b1));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,       32'h0,        1'b1));
      tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0,       32'h0,        1'b1));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'h11223344, 1'b0));
      tbl.push_back(mk(1'b1, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1));
      tbl.push_back(mk(1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h88995ABB, 1'b0));
      tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h01028304, 32'h0,        1'b0));
      tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0,        32'h00000001, 1'b0));
      tbl.push_back(mk(1'b0, 2'b01, 1'b0, 32'hFFE, 32'h0,        32'h00000102, 1'b0));
      tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'hFFD, 32'h0,        32'hFFFFFF83, 1'b0));
      tbl.push_back(mk(1'b0, 2'b01, 1'b0, 32'hFFC, 32'h0,        32'hFFFF8304, 1'b0));
      tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0,        32'h01028304, 1'b0));
      tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0,   32'h0,        32'h00003344, 1'b0));
      tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h2,   32'h0,        32'h00000022, 1'b0));

      // Reset state, both DUTs
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk($sformatf("reset_req_ready_%0d", s), 32'(req_ready), 32'd0);
         chk($sformatf("reset_rsp_valid_%0d", s), 32'(rsp_valid), 32'd0);
         chk($sformatf("reset_rdata_%0d", s), rsp_rdata, 32'h0);
         chk($sformatf("reset_err_%0d", s), 32'(rsp_err), 32'd0);
      end
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk($sformatf("release_req_ready_%0d", s), 32'(req_ready), 32'd1);
      end

      // Directed vectors on each configuration
      for (int s = 0; s < 2; s++) begin
         set_sel(s[0]);
         for (int i = 0; i < tbl.size(); i++) begin
            do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_dut%0d_rdata", i, s), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_dut%0d_err", i, s), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_dut%0d_latency", i, s), 32'(lat), 32'(s + 1));
         end
      end

      set_sel(1'b0);
      stream(100, 1);
      set_sel(1'b1);
      stream(100, 2);
      set_sel(1'b0);
      backpressure();
      set_sel(1'b0);
      reset_seq();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_ram_pipe.md
DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, data word width in bits; legal values are 32 only in this revision, and lanes are DATA_W/8 bytes.
REQ-002 The block SHALL take parameter DEPTH, default 131072, the number of words; it must be a power of two.
REQ-003 The block SHALL take parameter READ_LAT, default 1, the number of cycles from request acceptance to response availability; legal values are 1 and 2.
REQ-004 The block SHALL take parameter RSP_DEPTH, default 2, the response buffer entry count; it must be at least 2.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1, reset, synchronous and active-low.
REQ-007 The block SHALL have port req_valid, input, width 1, request present.
REQ-008 The block SHALL have port req_ready, output, width 1, request accepted when high with req_valid.
REQ-009 The block SHALL have port req_we, input, width 1; 1 means store and 0 means load.
REQ-010 The block SHALL have port req_size, input, width 2, encoded as 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 The block SHALL have port req_unsigned, input, width 1, load zero-extend when 1 and sign-extend when 0.
REQ-012 The block SHALL have port req_addr, input, width 32, byte address.
REQ-013 The block SHALL have port req_wdata, input, width DATA_W, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-014 The block SHALL have port rsp_valid, output, width 1, response present.
REQ-015 The block SHALL have port rsp_ready, input, width 1, response consumed when high with rsp_valid.
REQ-016 The block SHALL have port rsp_rdata, output, width DATA_W, load result, extended; 0 for stores and errors.
REQ-017 The block SHALL have port rsp_err, output, width 1, access fault.

Function
REQ-018 Acceptance SHALL occur when req_valid and req_ready are both high at a clock edge; at most one request is accepted per cycle.
REQ-019 Every accepted request, load or store, SHALL produce exactly one response, in acceptance order.
REQ-020 Fault SHALL be raised for any of: req_size==11; half with addr[0]!=0; word with addr[1:0]!=0; word index addr>>2 >= DEPTH.
REQ-021 A faulting request SHALL NOT modify memory, and its response SHALL carry rsp_err=1 and rsp_rdata=0.
REQ-022 A store SHALL commit to memory at its acceptance edge, with byte lanes selected by size and addr[1:0] and data shifted into lane position.
REQ-023 A load SHALL read the word at its acceptance edge, select the addressed byte or half, then zero- or sign-extend it per req_unsigned.
REQ-024 A load accepted in the cycle after a store to the same word SHALL return the post-store data.
REQ-025 A response SHALL be enqueued into the response buffer exactly READ_LAT cycles after acceptance.
REQ-026 With the buffer empty and rsp_ready=1, rsp_valid SHALL rise exactly READ_LAT cycles after acceptance.
REQ-027 The block SHALL maintain an outstanding counter covering in-flight and buffered responses: +1 on accept, -1 on rsp handshake, and unchanged when both occur in the same cycle.
REQ-028 req_ready SHALL be 1 iff outstanding < RSP_DEPTH, so the buffer never overflows and no response is ever dropped.
REQ-029 While the buffer is full and rsp_ready=0, req_ready SHALL be 0 and rsp_valid/rsp_rdata/rsp_err SHALL hold stable.
REQ-030 With rsp_ready held 1, the block SHALL sustain one request and one response per cycle.
REQ-031 The buffer SHALL wrap its read and write pointers modulo RSP_DEPTH with no bubble at the wrap point.

Reset
REQ-032 While rst=0 the block SHALL drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear the outstanding counter and pipeline, and empty the buffer.
REQ-033 req_ready SHALL be 1 in the first cycle after rst returns to 1.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight and buffered responses; stores already committed remain.
REQ-035 Memory contents SHALL NOT be reset.

Structure
REQ-036 The size encodings, default parameter values and fault-condition constants SHALL reside in a shared header/package alongside the existing bus-width defines.
REQ-037 The response buffer SHALL be a separate sub-module, rsp_fifo, parametrised by width (DATA_W+1) and RSP_DEPTH.
REQ-038 The memory array SHALL be four byte-lane arrays so that no read-modify-write is needed.

Verification
REQ-039 The bench SHALL check: store word 0x8899AABB @0x10, then load byte @0x13 signed -> rsp_rdata=0xFFFFFF88, err=0; same load unsigned -> 0x00000088.
REQ-040 The bench SHALL check: store half 0x1234 @0x22, then load word @0x20 -> upper half 0x1234, lower half unchanged.
REQ-041 The bench SHALL check: load word @0x21 -> rsp_err=1, rdata=0; load word @(DEPTH*4) -> rsp_err=1; a prior write at the faulting address is unchanged.
REQ-042 The bench SHALL check: rsp_ready=0 with RSP_DEPTH=2 and 3 back-to-back requests -> only 2 accepted, req_ready=0, and outputs stable; on rsp_ready=1 the responses drain in order.
REQ-043 The bench SHALL check: 100 back-to-back loads with rsp_ready=1 and READ_LAT=2 -> one response per cycle, first response 2 cycles after first accept.
REQ-044 The bench SHALL check: assert rst with 2 responses pending -> rsp_valid=0 next cycle, req_ready=1 one cycle after release, and no stale response emerges.
